// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Writer side of the processor's instruction ROM. A session starts with a
// one-cycle start pulse and then consumes a byte stream over a valid/ready
// handshake:
//   2 bytes  length in words, big-endian
//   4*N      instruction words, each big-endian (MSB byte first)
//   1 byte   XOR of all instruction bytes
// Every assembled word is written to instruction memory with a one-cycle
// mem_we pulse. The processor is held in reset (cpu_reset=1) until an image
// whose length fits the memory and whose checksum matches has been received.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   start        one-cycle request to begin a load session
//   in_data      stream byte
//   in_valid     in_data valid
//   in_ready     loader accepts a byte this cycle
//   mem_we       instruction memory write enable (one pulse per word)
//   mem_addr     word address of the write
//   mem_wdata    instruction word to write
//   cpu_reset    active-high processor reset
//   done         image loaded and verified (level)
//   error        session aborted: oversize or bad checksum (level)
//   words_loaded words written in the current session
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_CHECK  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERROR  = 3'd7;

  // Largest legal length, widened by one bit so 2^ADDR_WIDTH itself fits.
  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

  logic [2:0]            state_q,    state_d;
  logic [15:0]           len_q,      len_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [23:0]           word_q,     word_d;     // first three bytes of a word
  logic [7:0]            csum_q,     csum_d;
  logic [ADDR_WIDTH:0]   words_q,    words_d;
  logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
  logic [31:0]           wdata_q,    wdata_d;

  logic xfer;
  logic [16:0] len_rx;  // full length as it completes in LEN_LO

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred; blocking '=' is correct in always_comb.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    csum_d     = csum_q;
    words_d    = words_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
               (state_q == S_DATA)   || (state_q == S_CHECK);
    xfer     = in_valid && in_ready;
    len_rx   = {1'b0, len_q[15:8], in_data};

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d    = S_LEN_HI;
          len_d      = '0;
          byte_cnt_d = '0;
          csum_d     = '0;
          words_d    = '0;
        end
      end

      S_LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = in_data;
          state_d     = S_LEN_LO;
        end
      end

      S_LEN_LO: begin
        if (xfer) begin
          len_d[7:0] = in_data;
          if (len_rx > CAPACITY)   state_d = S_ERROR;
          else if (len_rx == '0)   state_d = S_CHECK;
          else                     state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (xfer) begin
          csum_d     = csum_q ^ in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // Capture address and word now so they are stable during WRITE
            // and hold afterwards.
            addr_d  = words_q[ADDR_WIDTH-1:0];
            wdata_d = {word_q, in_data};
            state_d = S_WRITE;
          end else begin
            word_d = {word_q[15:0], in_data};
          end
        end
      end

      S_WRITE: begin
        words_d = words_q + 1'b1;
        if ((16'(words_q) + 16'd1) == len_q) state_d = S_CHECK;
        else                                 state_d = S_DATA;
      end

      S_CHECK: begin
        if (xfer) begin
          state_d = (in_data == csum_q) ? S_DONE : S_ERROR;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // pre-edge values of its inputs regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      csum_q     <= '0;
      words_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      csum_q     <= csum_d;
      words_q    <= words_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Status outputs are pure decodes of the state register, so they change
  // only on clock edges (or reset) and never glitch with input activity.
  assign mem_we       = (state_q == S_WRITE);
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign done         = (state_q == S_DONE);
  assign error        = (state_q == S_ERROR);
  assign cpu_reset    = (state_q != S_DONE);
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Directed bench for imem_loader. Each instruction word sent pushes its
// expected {addr, data} onto a scoreboard queue; a monitor pops and compares
// on every mem_we pulse. Status outputs are checked at directed points.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int AW = 6;

  logic          clk;
  logic          reset;
  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_reset;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_reset    (cpu_reset),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t       sb_q[$];
  int        total = 0;
  int        bad   = 0;
  logic [7:0] model_csum;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write monitor: every mem_we pulse must match the oldest expected write,
  // and the loader must not be accepting bytes while it writes.
  always @(negedge clk) begin
    if (reset && mem_we) begin
      wr_t exp_wr;
      check("wr_in_ready_low", 32'(in_ready), 32'd0);
      check("wr_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        exp_wr = sb_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(exp_wr.addr));
        check("wr_data", mem_wdata, exp_wr.data);
      end
    end
  end

  // Called on a falling edge; returns on the falling edge after the transfer.
  task automatic send_byte(input logic [7:0] b, input bit keep);
    int waits;
    waits    = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    check("byte_accept_bound", 32'(in_ready), 32'd1);
    @(negedge clk);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [AW-1:0] addr, input logic [31:0] w, input bit keep);
    wr_t e;
    e.addr = addr;
    e.data = w;
    sb_q.push_back(e);
    for (int i = 3; i >= 0; i--) begin
      logic [7:0] b;
      b = w[i*8 +: 8];
      model_csum = model_csum ^ b;
      send_byte(b, keep);
    end
  endtask

  task automatic pulse_start();
    model_csum = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic exp_done, input logic exp_err,
                              input logic exp_cpu, input int exp_words);
    check({tag, "_done"},  32'(done),         32'(exp_done));
    check({tag, "_error"}, 32'(error),        32'(exp_err));
    check({tag, "_cpu"},   32'(cpu_reset),    32'(exp_cpu));
    check({tag, "_words"}, 32'(words_loaded), 32'(exp_words));
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    model_csum = 8'h00;
    repeat (2) @(negedge clk);

    // ---- reset state ----
    check("rst_in_ready", 32'(in_ready),  32'd0);
    check("rst_mem_we",   32'(mem_we),    32'd0);
    check("rst_mem_addr", 32'(mem_addr),  32'd0);
    check("rst_wdata",    mem_wdata,      32'd0);
    check_status("rst", 1'b0, 1'b0, 1'b1, 0);
    reset = 1'b1;
    @(negedge clk);

    // ---- 3-word image, good checksum; start/in_valid coincide in IDLE ----
    in_valid = 1'b1;
    in_data  = 8'hFF;
    check("idle_in_ready", 32'(in_ready), 32'd0);
    pulse_start();
    in_valid = 1'b0;
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    // start during DATA must be ignored
    start = 1'b1;
    send_word(6'd0, 32'h20080005, 1'b0);
    start = 1'b0;
    send_word(6'd1, 32'h2009000A, 1'b0);
    send_word(6'd2, 32'h01095020, 1'b0);
    check("good_csum_value", 32'(model_csum), 32'h76);  // XOR of the 12 data bytes
    send_byte(model_csum, 1'b0);
    check_status("load3", 1'b1, 1'b0, 1'b0, 3);
    check("load3_sb_empty", 32'(sb_q.size()), 32'd0);

    // ---- same stream, bad checksum ----
    pulse_start();
    check("restart_cpu_reset", 32'(cpu_reset), 32'd1);
    check("restart_done",      32'(done),      32'd0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    send_word(6'd0, 32'h20080005, 1'b0);
    send_word(6'd1, 32'h2009000A, 1'b0);
    send_word(6'd2, 32'h01095020, 1'b0);
    send_byte(model_csum ^ 8'h01, 1'b0);
    check_status("badcs", 1'b0, 1'b1, 1'b1, 3);
    check("badcs_sb_empty", 32'(sb_q.size()), 32'd0);

    // ---- oversize length 0x0041 ----
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h41, 1'b0);
    check_status("over", 1'b0, 1'b1, 1'b1, 0);
    check("over_in_ready", 32'(in_ready), 32'd0);

    // ---- boundary length 0x0040 is accepted, then abandoned by reset ----
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h40, 1'b0);
    check("cap_error",    32'(error),    32'd0);
    check("cap_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // ---- length 0, checksum 00 ----
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    check_status("len0", 1'b1, 1'b0, 1'b0, 0);

    // ---- backpressure: in_valid held high across a 2-word image ----
    pulse_start();
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_word(6'd0, 32'hDEADBEEF, 1'b1);
    send_word(6'd1, 32'h12345678, 1'b1);
    send_byte(model_csum, 1'b0);
    check_status("bp", 1'b1, 1'b0, 1'b0, 2);
    check("bp_sb_empty", 32'(sb_q.size()), 32'd0);

    // ---- async reset during the second word, then a fresh 1-word session ----
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_word(6'd0, 32'hCAFEF00D, 1'b0);
    send_byte(8'hAB, 1'b0);
    send_byte(8'hCD, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("arst_in_ready", 32'(in_ready),  32'd0);
    check("arst_mem_we",   32'(mem_we),    32'd0);
    check("arst_mem_addr", 32'(mem_addr),  32'd0);
    check("arst_wdata",    mem_wdata,      32'd0);
    check_status("arst", 1'b0, 1'b0, 1'b1, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_word(6'd0, 32'h0BADC0DE, 1'b0);
    send_byte(model_csum, 1'b0);
    check_status("fresh", 1'b1, 1'b0, 1'b0, 1);
    check("fresh_sb_empty", 32'(sb_q.size()), 32'd0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
